// File: rtl/verdict_ser_pkg.sv
// Shared types and helpers for the monitor verdict serializer.
// Contents:
//   ser_state_e - serializer FSM states
//   rec_w()     - record width {ts, aktv mask, values}
//   REC_W       - record width for the default configuration
//   pack_hdr()  - builds a header word: ts in the top TS_W bits, mask in the low bits
//   next_set()  - lowest set mask bit strictly above a given index (-1 if none)
// The helpers work on widened vectors (MASK_MAX / HDR_MAX) so one function
// serves every parameterization. Callers zero-extend their inputs and truncate the result.
package verdict_ser_pkg;

  localparam int NUM_OUTPUTS_DEF = 7;
  localparam int DATA_W_DEF      = 64;
  localparam int TS_W_DEF        = 32;
  localparam int DEPTH_DEF       = 8;

  localparam int MASK_MAX = 64;   // upper bound on NUM_OUTPUTS
  localparam int HDR_MAX  = 256;  // upper bound on DATA_W

  typedef enum logic [1:0] {IDLE, HDR, VAL} ser_state_e;

  typedef logic [MASK_MAX-1:0] mask_t;
  typedef logic [HDR_MAX-1:0]  hdr_t;

  function automatic int rec_w(input int ts_w, input int n, input int dw);
    return ts_w + n + n * dw;
  endfunction

  localparam int REC_W = rec_w(TS_W_DEF, NUM_OUTPUTS_DEF, DATA_W_DEF);

  // ts must already be zero above ts_w. Bits between the fields stay zero.
  function automatic hdr_t pack_hdr(input hdr_t ts, input hdr_t mask,
                                    input int ts_w, input int dw);
    return (ts << (dw - ts_w)) | mask;
  endfunction

  // Descending scan so the lowest qualifying bit wins.
  function automatic int next_set(input mask_t mask, input int after);
    int r;
    r = -1;
    for (int i = MASK_MAX - 1; i >= 0; i--)
      if (i > after && mask[i]) r = i;
    return r;
  endfunction

endpackage

// File: rtl/verdict_fifo.sv
// Synchronous record FIFO for the verdict serializer.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   push_i, wdata_i  write request and record; ignored when full
//   pop_i            read request (advance head); ignored when empty
//   rdata_o          head record (combinational read of the head slot)
//   full_o, empty_o  derived from pointers that carry an extra wrap bit
//   level_o          number of stored records
// DEPTH must be a power of two and at least 2.
module verdict_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];

  // full/empty use pre-edge pointers, so a same-edge pop never frees a slot for the push.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/monitor_verdict_serializer.sv
// Buffers monitor verdicts and streams them out as words.
// On each enabled edge with any active output, a record {ts, aktv, values} is queued.
// Each record drains as a header word, then one word per set aktv bit in
// ascending index order. m_last marks the final word.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       capture / timestamp enable
//   out_data, out_aktv       monitor outputs (output_i at [i*DATA_W +: DATA_W]) and active flags
//   m_data, m_valid, m_last  stream word out; m_ready from the sink
//   overflow                 sticky: a record was dropped on a full FIFO
//   fifo_level               records currently queued
//   drop_count               only with VERDICT_SER_DROP_CNT_EN: saturating count of dropped records
// Build option: define VERDICT_SER_DROP_CNT_EN to add drop_count.
// Constraint: TS_W + NUM_OUTPUTS <= DATA_W.
module monitor_verdict_serializer
  import verdict_ser_pkg::*;
#(
  parameter int NUM_OUTPUTS = NUM_OUTPUTS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TS_W        = TS_W_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
  input  logic [NUM_OUTPUTS-1:0]        out_aktv,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          overflow,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_level
`ifdef VERDICT_SER_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_count
`endif
);
  localparam int RW = rec_w(TS_W, NUM_OUTPUTS, DATA_W);
  localparam int IW = $clog2(NUM_OUTPUTS + 1);

  logic [TS_W-1:0]   ts_q;
  logic              overflow_q;
  logic              cap, pop, full, empty, hs;
  logic [RW-1:0]     head;
  logic [TS_W-1:0]   hd_ts;
  logic [NUM_OUTPUTS-1:0] hd_mask;

  ser_state_e                    state_q;
  logic [NUM_OUTPUTS-1:0]        mask_q;
  logic [NUM_OUTPUTS*DATA_W-1:0] vals_q;
  logic [IW-1:0]                 idx_q;
  logic [DATA_W-1:0]             m_data_q;
  logic                          m_valid_q, m_last_q;

  logic [DATA_W-1:0] hdr_d, word_d;
  int                cur, nb, nb2, sel;

  assign cap = en && (|out_aktv);
  assign pop = (state_q == IDLE) && !empty;
  assign hs  = m_valid_q && m_ready;

  verdict_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap),
    .wdata_i ({ts_q, out_aktv, out_data}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  assign hd_ts   = head[RW-1 -: TS_W];
  assign hd_mask = head[NUM_OUTPUTS*DATA_W +: NUM_OUTPUTS];

  // In HDR the next word is the lowest set bit. In VAL it is the bit above the one being presented.
  always_comb begin
    hdr_d  = DATA_W'(pack_hdr(hdr_t'(hd_ts), hdr_t'(hd_mask), TS_W, DATA_W));
    cur    = (state_q == HDR) ? -1 : int'(idx_q);
    nb     = next_set(mask_t'(mask_q), cur);
    nb2    = next_set(mask_t'(mask_q), nb);
    sel    = (nb < 0) ? 0 : nb;
    word_d = vals_q[sel*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else if (en) ts_q <= ts_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else if (cap && full) overflow_q <= 1'b1;
  end

`ifdef VERDICT_SER_DROP_CNT_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else if (cap && full && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
  end
  assign drop_count = drop_q;
`endif

  // Outputs only change on a handshake, or when loading from IDLE, so they hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      vals_q    <= '0;
      idx_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            mask_q    <= hd_mask;
            vals_q    <= head[NUM_OUTPUTS*DATA_W-1:0];
            m_data_q  <= hdr_d;
            m_valid_q <= 1'b1;
            m_last_q  <= (hd_mask == '0);
            state_q   <= HDR;
          end
        end
        HDR, VAL: begin
          if (hs) begin
            if (nb >= 0) begin
              m_data_q <= word_d;
              m_last_q <= (nb2 < 0);
              idx_q    <= IW'(nb);
              state_q  <= VAL;
            end else begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_monitor_verdict_serializer.sv
module tb_monitor_verdict_serializer;
  logic         clk = 0;
  logic         rst, en, m_ready;
  logic [447:0] out_data;
  logic [6:0]   out_aktv;
  logic [63:0]  m_data;
  logic         m_valid, m_last, overflow;
  logic [3:0]   fifo_level;
`ifdef VERDICT_SER_DROP_CNT_EN
  logic [15:0]  drop_count;
`endif

  monitor_verdict_serializer #(.NUM_OUTPUTS(7), .DATA_W(64), .TS_W(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .overflow(overflow), .fifo_level(fifo_level)
`ifdef VERDICT_SER_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int          cmps = 0, errs = 0;
  logic [3:0]  tsm = 0;
  logic [64:0] q[$];   // {last, data}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected words of one record: header, then set bits ascending.
  task automatic exp_rec(input logic [3:0] ts, input logic [6:0] a, input logic [447:0] d);
    int lst;
    lst = -1;
    for (int i = 0; i < 7; i++) if (a[i]) lst = i;
    q.push_back({(a == 7'd0), ts, 53'd0, a});
    for (int i = 0; i < 7; i++)
      if (a[i]) q.push_back({(i == lst), d[i*64 +: 64]});
  endtask

  task automatic step();
    logic e;
    e = en && !rst;
    @(posedge clk);
    #1;
    if (e) tsm = tsm + 4'd1;
  endtask

  task automatic setv(input int i, input logic [63:0] v);
    out_data[i*64 +: 64] = v;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; out_aktv = 0; m_ready = 0;
    q.delete();
    step();
    rst = 0;
    tsm = 0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 300) begin
      step();
      n++;
    end
    cmps++;
    if (n >= 300) begin
      errs++;
      $display("FAIL %s_drain: got %0d words pending want 0", nm, q.size());
    end
  endtask

  // Scoreboard monitor: compares handshaken words and checks stability under stall.
  logic        hold_p = 0, hold_l = 0;
  logic [63:0] hold_d = 0;
  logic [64:0] ew;
  always @(negedge clk) begin
    if (rst) hold_p = 0;
    else begin
      if (hold_p) begin
        chk("hold_valid", 64'(m_valid), 64'd1);
        chk("hold_data", m_data, hold_d);
        chk("hold_last", 64'(m_last), 64'(hold_l));
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          cmps++; errs++;
          $display("FAIL unexpected_word: got %h want none", m_data);
        end else begin
          ew = q.pop_front();
          chk("word_data", m_data, ew[63:0]);
          chk("word_last", 64'(m_last), 64'(ew[64]));
        end
      end
      hold_p = m_valid && !m_ready;
      hold_d = m_data;
      hold_l = m_last;
    end
  end

  initial begin
    rst = 1; en = 0; m_ready = 1; out_aktv = 0; out_data = '0;
    step(); step();
    rst = 0; tsm = 0;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last", 64'(m_last), 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
`ifdef VERDICT_SER_DROP_CNT_EN
    chk("rst_drop", 64'(drop_count), 64'd0);
`endif

    // 1: single event at ts=5
    m_ready = 1; en = 1;
    repeat (5) step();
    out_aktv = 7'b0000011; setv(0, 64'd1); setv(1, 64'd1);
    exp_rec(4'd5, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    chk("t1_level_k", 64'(fifo_level), 64'd1);
    chk("t1_valid_k", 64'(m_valid), 64'd0);
    step();
    chk("t1_valid_k1", 64'(m_valid), 64'd1);
    chk("t1_hdr", m_data, 64'h5000_0000_0000_0003);
    drain("t1");

    // 2: backpressure during VAL
    m_ready = 1; en = 1; out_aktv = 7'b0010101;
    setv(0, 64'd10); setv(2, 64'hFFFF_FFFF_FFFF_FFFD); setv(4, 64'h1234_5678_9ABC_DEF0);
    exp_rec(tsm, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    step(); step();
    m_ready = 0;
    repeat (10) step();
    chk("t2_stall_valid", 64'(m_valid), 64'd1);
    chk("t2_stall_data", m_data, 64'd10);
    chk("t2_stall_last", 64'(m_last), 64'd0);
    m_ready = 1;
    drain("t2");

    // 3: overflow; record A parked in the serializer, then 9 pushes
    m_ready = 0; en = 1; out_aktv = 7'b0000001; setv(0, 64'd100);
    exp_rec(tsm, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    step();
    for (int i = 1; i <= 9; i++) begin
      en = 1; out_aktv = 7'b1000000; setv(6, 64'(i));
      if (i <= 8) exp_rec(tsm, out_aktv, out_data);
      step();
      if (i == 8) chk("t3_ovf_before", 64'(overflow), 64'd0);
    end
    en = 0; out_aktv = 0;
    chk("t3_level", 64'(fifo_level), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd1);
`ifdef VERDICT_SER_DROP_CNT_EN
    chk("t3_drop", 64'(drop_count), 64'd1);
`endif
    m_ready = 1;
    drain("t3");
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 4: full FIFO, push on the same edge as the IDLE pop
    do_reset();
    chk("t4_rst_ovf", 64'(overflow), 64'd0);
    en = 1; out_aktv = 7'b0000001; setv(0, 64'd200);
    exp_rec(tsm, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    step();
    for (int i = 1; i <= 8; i++) begin
      en = 1; out_aktv = 7'b0000010; setv(1, 64'(1000 + i));
      exp_rec(tsm, out_aktv, out_data);
      step();
    end
    en = 0; out_aktv = 0;
    chk("t4_level_full", 64'(fifo_level), 64'd8);
    m_ready = 1;
    step(); step();
    en = 1; out_aktv = 7'b0000010; setv(1, 64'd2000);
    step();
    en = 0; out_aktv = 0;
    chk("t4_level_after", 64'(fifo_level), 64'd7);
    chk("t4_overflow", 64'(overflow), 64'd1);
`ifdef VERDICT_SER_DROP_CNT_EN
    chk("t4_drop", 64'(drop_count), 64'd1);
`endif
    drain("t4");

    // 5: en gating and timestamp wrap
    do_reset();
    m_ready = 1; en = 0; out_aktv = 7'b0000001; setv(0, 64'd5);
    repeat (3) step();
    chk("t5_gate_level", 64'(fifo_level), 64'd0);
    chk("t5_gate_valid", 64'(m_valid), 64'd0);
    en = 1; setv(0, 64'd7);
    exp_rec(4'h0, out_aktv, out_data);
    step();
    out_aktv = 0;
    repeat (14) step();
    out_aktv = 7'b0000001; setv(0, 64'd8);
    exp_rec(4'hF, out_aktv, out_data);
    step();
    setv(0, 64'd9);
    exp_rec(4'h0, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    drain("t5");

    // 6: reset in the middle of a 4-word record
    do_reset();
    m_ready = 1; en = 1; out_aktv = 7'b0000111;
    setv(0, 64'd11); setv(1, 64'd22); setv(2, 64'd33);
    exp_rec(4'h0, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    step(); step();
    m_ready = 0;
    step(); step();
    chk("t6_mid_valid", 64'(m_valid), 64'd1);
    rst = 1; q.delete();
    step();
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    rst = 0; tsm = 0;
    m_ready = 1; en = 1; out_aktv = 7'b0000001; setv(0, 64'd55);
    exp_rec(4'h0, out_aktv, out_data);
    step();
    en = 0; out_aktv = 0;
    drain("t6");

    chk("end_queue", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
